// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: legacy ALUop/funct codes,
// the internal operation enum and the execute-unit state machine states.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // 4-bit control lines still consumed by the existing datapath
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_NONE = 4'b1111;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU,
    OP_DIV, OP_DIVU, OP_ILL
  } alu_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} alu_state_e;

  function automatic logic op_is_signed(alu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of (ALUop, funct) into the internal op, plus the
// legacy 4-bit ALU control lines for the older datapath.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_op_e    op,
  output logic [3:0] alu_ctrl,
  output logic       is_multicycle,
  output logic       illegal
);

  always_comb begin
    op = OP_ILL;
    case (alu_op)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   op = OP_ADD;
          F_SUB:   op = OP_SUB;
          F_AND:   op = OP_AND;
          F_OR:    op = OP_OR;
          F_XOR:   op = OP_XOR;
          F_NOR:   op = OP_NOR;
          F_SLT:   op = OP_SLT;
          F_SLTU:  op = OP_SLTU;
          F_SLL:   op = OP_SLL;
          F_SRL:   op = OP_SRL;
          F_SRA:   op = OP_SRA;
          F_MFHI:  op = OP_MFHI;
          F_MFLO:  op = OP_MFLO;
          F_MULT:  op = OP_MULT;
          F_MULTU: op = OP_MULTU;
          F_DIV:   op = OP_DIV;
          F_DIVU:  op = OP_DIVU;
          default: op = OP_ILL;
        endcase
      end
      ALUOP_ILL: op = OP_ILL;
      default:   op = OP_ILL;
    endcase
  end

  always_comb begin
    alu_ctrl = CTRL_NONE;
    case (op)
      OP_ADD:  alu_ctrl = CTRL_ADD;
      OP_SUB:  alu_ctrl = CTRL_SUB;
      OP_AND:  alu_ctrl = CTRL_AND;
      OP_OR:   alu_ctrl = CTRL_OR;
      OP_SLT:  alu_ctrl = CTRL_SLT;
      default: alu_ctrl = CTRL_NONE;
    endcase
  end

  assign is_multicycle = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign illegal       = (op == OP_ILL);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes, computes and registers one op per handshake.
// mult/div iterate one bit per cycle on a shared adder into HI/LO.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       inst_funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  alu_state_e state_reg, state_next, start_state;
  alu_op_e    dec_op, op_reg;
  logic [3:0] dec_ctrl;
  logic       dec_multi, dec_illegal, accept;

  logic [WIDTH-1:0] a_reg, b_reg, d_reg, p_hi_reg, p_lo_reg;
  logic [SHW-1:0]   cnt_reg;
  logic             prep_reg, qneg_reg, rneg_reg;
  logic [WIDTH-1:0] result_reg, hi_reg, lo_reg;
  logic             zero_reg, err_reg;

  alu_op_decode u_decode (
    .alu_op        (ALUop),
    .funct         (inst_funct),
    .op            (dec_op),
    .alu_ctrl      (dec_ctrl),
    .is_multicycle (dec_multi),
    .illegal       (dec_illegal)
  );

  // A finished result can be drained and replaced in the same cycle
  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign err       = err_reg;
  assign hi        = hi_reg;
  assign lo        = lo_reg;

  // Single-cycle datapath; the legacy control lines still drive add/sub/and/or/slt
  logic [WIDTH-1:0] legacy_res, sc_result;

  always_comb begin
    legacy_res = '0;
    case (dec_ctrl)
      CTRL_AND: legacy_res = a & b;
      CTRL_OR:  legacy_res = a | b;
      CTRL_ADD: legacy_res = a + b;
      CTRL_SUB: legacy_res = a - b;
      CTRL_SLT: legacy_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default:  legacy_res = '0;
    endcase
  end

  always_comb begin
    sc_result = '0;
    case (dec_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: sc_result = legacy_res;
      OP_XOR:  sc_result = a ^ b;
      OP_NOR:  sc_result = ~(a | b);
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  sc_result = b << shamt;
      OP_SRL:  sc_result = b >> shamt;
      OP_SRA:  sc_result = $signed(b) >>> shamt;
      OP_MFHI: sc_result = hi_reg;
      OP_MFLO: sc_result = lo_reg;
      default: sc_result = '0;
    endcase
  end

  always_comb begin
    start_state = ST_DONE;
    if (dec_op == OP_MULT || dec_op == OP_MULTU)
      start_state = ST_MUL;
    else if (dec_op == OP_DIV || dec_op == OP_DIVU)
      start_state = ST_DIV;
  end

  // Shared adder: shift-add for MUL, trial subtract for DIV
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_sub;
  logic [WIDTH:0]   add_sum;

  always_comb begin
    add_x   = p_hi_reg;
    add_y   = p_lo_reg[0] ? d_reg : '0;
    add_sub = 1'b0;
    if (state_reg == ST_DIV) begin
      add_x   = {p_hi_reg[WIDTH-2:0], p_lo_reg[WIDTH-1]};
      add_y   = d_reg;
      add_sub = 1'b1;
    end
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_sub ? ~add_y : add_y} + {{WIDTH{1'b0}}, add_sub};

  logic             div_ge;
  logic [WIDTH-1:0] iter_hi_n, iter_lo_n;

  // Carry out of the shifted-away remainder bit also means "fits"
  assign div_ge = p_hi_reg[WIDTH-1] | add_sum[WIDTH];

  always_comb begin
    if (state_reg == ST_DIV) begin
      iter_hi_n = div_ge ? add_sum[WIDTH-1:0] : add_x;
      iter_lo_n = {p_lo_reg[WIDTH-2:0], div_ge};
    end else begin
      iter_hi_n = add_sum[WIDTH:1];
      iter_lo_n = {add_sum[0], p_lo_reg[WIDTH-1:1]};
    end
  end

  // Magnitude conversion and final sign fix-up
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0] fin_hi, fin_lo;
  logic             fin_err;

  assign sgn      = op_is_signed(op_reg);
  assign a_neg    = sgn & a_reg[WIDTH-1];
  assign b_neg    = sgn & b_reg[WIDTH-1];
  assign a_mag    = a_neg ? -a_reg : a_reg;
  assign b_mag    = b_neg ? -b_reg : b_reg;
  assign prod_mag = {iter_hi_n, iter_lo_n};
  assign prod_fix = qneg_reg ? -prod_mag : prod_mag;

  always_comb begin
    fin_hi  = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo  = prod_fix[WIDTH-1:0];
    fin_err = 1'b0;
    if (state_reg == ST_DIV) begin
      if (b_reg == '0) begin
        fin_hi  = a_reg;
        fin_lo  = '1;
        fin_err = 1'b1;
      end else begin
        fin_hi = rneg_reg ? -iter_hi_n : iter_hi_n;
        fin_lo = qneg_reg ? -iter_lo_n : iter_lo_n;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:        if (accept) state_next = start_state;
      ST_MUL, ST_DIV: if (!prep_reg && cnt_reg == CNT_LAST) state_next = ST_DONE;
      ST_DONE:        if (out_ready) state_next = accept ? start_state : ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg     <= OP_ADD;
      a_reg      <= '0;
      b_reg      <= '0;
      d_reg      <= '0;
      p_hi_reg   <= '0;
      p_lo_reg   <= '0;
      cnt_reg    <= '0;
      prep_reg   <= 1'b0;
      qneg_reg   <= 1'b0;
      rneg_reg   <= 1'b0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      err_reg    <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else if (accept) begin
      if (dec_multi) begin
        op_reg   <= dec_op;
        a_reg    <= a;
        b_reg    <= b;
        prep_reg <= 1'b1;
        cnt_reg  <= '0;
      end else begin
        result_reg <= sc_result;
        zero_reg   <= (sc_result == '0);
        err_reg    <= dec_illegal;
      end
    end else if (state_reg == ST_MUL || state_reg == ST_DIV) begin
      if (prep_reg) begin
        prep_reg <= 1'b0;
        p_hi_reg <= '0;
        d_reg    <= (state_reg == ST_MUL) ? a_mag : b_mag;
        p_lo_reg <= (state_reg == ST_MUL) ? b_mag : a_mag;
        qneg_reg <= a_neg ^ b_neg;
        rneg_reg <= a_neg;
      end else begin
        p_hi_reg <= iter_hi_n;
        p_lo_reg <= iter_lo_n;
        cnt_reg  <= cnt_reg + SHW'(1);
        if (cnt_reg == CNT_LAST) begin
          cnt_reg    <= '0;
          hi_reg     <= fin_hi;
          lo_reg     <= fin_lo;
          result_reg <= fin_lo;
          zero_reg   <= (fin_lo == '0);
          err_reg    <= fin_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results are queued at issue
// time and checked by a monitor when each result is handed off.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, zero, err;
  logic [1:0]  ALUop = 2'b00;
  logic [5:0]  inst_funct = 6'd0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [31:0] result, hi, lo;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        z;
    logic        e;
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUop      (ALUop),
    .inst_funct (inst_funct),
    .shamt      (shamt),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .err        (err),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk32(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(string tag, logic got, logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Result handoff: compare against the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_output got=%h exp=no queued op", result);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk32({mon_e.tag, ".result"}, result, mon_e.res);
        chk1 ({mon_e.tag, ".zero"},   zero,   mon_e.z);
        chk1 ({mon_e.tag, ".err"},    err,    mon_e.e);
        chk32({mon_e.tag, ".hi"},     hi,     mon_e.h);
        chk32({mon_e.tag, ".lo"},     lo,     mon_e.l);
        $display("txn %s result=%h zero=%b err=%b hi=%h lo=%h", mon_e.tag, result, zero, err, hi, lo);
      end
    end
  end

  task automatic send(string tag, logic [1:0] op, logic [5:0] f, logic [4:0] sh,
                      logic [31:0] aa, logic [31:0] bb, logic [31:0] eres, logic eerr,
                      logic upd, logic [31:0] nh, logic [31:0] nl);
    exp_t e;
    int   n;
    if (upd) begin
      model_hi = nh;
      model_lo = nl;
    end
    e.tag = tag; e.res = eres; e.z = (eres == 32'd0); e.e = eerr;
    e.h = model_hi; e.l = model_lo;
    sb.push_back(e);
    ALUop = op; inst_funct = f; shamt = sh; a = aa; b = bb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    assert (in_ready === 1'b1) else begin
      bad++;
      $error("FAIL %s.accept_timeout got in_ready=%b exp=1", tag, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : stim
    int          lat;
    int          c0;
    logic        rdy_seen;
    logic [31:0] xa, xb;

    repeat (3) @(posedge clk);
    #1;
    chk1 ("reset.out_valid", out_valid, 1'b0);
    chk1 ("reset.in_ready",  in_ready,  1'b1);
    chk32("reset.result",    result,    32'd0);
    chk1 ("reset.zero",      zero,      1'b1);
    chk1 ("reset.err",       err,       1'b0);
    chk32("reset.hi",        hi,        32'd0);
    chk32("reset.lo",        lo,        32'd0);
    rst = 1'b0;
    idle(1);

    send("add", 2'b00, 6'd0, 5'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 0, 0);
    chk1("add.valid_next_cycle", out_valid, 1'b1);
    send("sub_eq", 2'b01, 6'd0, 5'd0, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 0, 0);
    send("slt", 2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 0, 0);
    send("sltu", 2'b10, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 0, 0);
    send("sra", 2'b10, 6'b000011, 5'd4, 32'd0, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 0, 0);

    // Back-to-back single-cycle ops, one per clock
    xa = 32'hA5A5F00F;
    xb = 32'h0FF00FF0;
    c0 = cyc;
    send("xor",  2'b10, 6'b100110, 5'd0, xa, xb, xa ^ xb, 1'b0, 1'b0, 0, 0);
    send("nor",  2'b10, 6'b100111, 5'd0, xa, xb, ~(xa | xb), 1'b0, 1'b0, 0, 0);
    send("and",  2'b10, 6'b100100, 5'd0, xa, xb, xa & xb, 1'b0, 1'b0, 0, 0);
    send("or",   2'b10, 6'b100101, 5'd0, xa, xb, xa | xb, 1'b0, 1'b0, 0, 0);
    send("sll",  2'b10, 6'b000000, 5'd31, 32'd0, 32'd1, 32'h80000000, 1'b0, 1'b0, 0, 0);
    send("srl",  2'b10, 6'b000010, 5'd31, 32'd0, 32'h80000000, 32'd1, 1'b0, 1'b0, 0, 0);
    send("addw", 2'b10, 6'b100000, 5'd0, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0, 1'b0, 0, 0);
    send("subw", 2'b10, 6'b100010, 5'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 0);
    chk32("b2b.cycles", cyc - c0, 32'd8);

    send("mult", 2'b10, 6'b011000, 5'd0, -32'sd3, 32'd7, 32'hFFFFFFEB, 1'b0,
         1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk32("mult.latency", lat, 32'd33);
    chk1 ("mult.in_ready_low", rdy_seen, 1'b0);
    send("mflo", 2'b10, 6'b010010, 5'd0, 32'd0, 32'd0, 32'hFFFFFFEB, 1'b0, 1'b0, 0, 0);
    send("mfhi", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 0);

    // mfhi issued right behind a div waits for it, then sees the new HI
    send("div", 2'b10, 6'b011010, 5'd0, -32'sd7, 32'd2, 32'hFFFFFFFD, 1'b0,
         1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    send("mfhi_div", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 0);
    send("divu0", 2'b10, 6'b011011, 5'd0, 32'h1234, 32'd0, 32'hFFFFFFFF, 1'b1,
         1'b1, 32'h1234, 32'hFFFFFFFF);
    send("div_min", 2'b10, 6'b011010, 5'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0,
         1'b1, 32'd0, 32'h80000000);
    send("multu", 2'b10, 6'b011001, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0,
         1'b1, 32'hFFFFFFFE, 32'd1);
    send("divu", 2'b10, 6'b011011, 5'd0, 32'd100, 32'd7, 32'd14, 1'b0,
         1'b1, 32'd2, 32'd14);
    send("div_negb", 2'b10, 6'b011010, 5'd0, 32'd7, -32'sd2, 32'hFFFFFFFD, 1'b0,
         1'b1, 32'd1, 32'hFFFFFFFD);
    send("ill_funct", 2'b10, 6'b111111, 5'd0, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 0, 0);
    send("ill_aluop", 2'b11, 6'b100000, 5'd0, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, 0, 0);

    // Back-pressure on a finished add
    idle(1);
    out_ready = 1'b0;
    send("bp_add", 2'b00, 6'd0, 5'd0, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk32("bp.result", result, 32'd123);
      chk1 ("bp.in_ready", in_ready, 1'b0);
      chk1 ("bp.out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk1("bp.resume_ready", in_ready, 1'b1);
    c0 = cyc;
    send("bp_next", 2'b01, 6'd0, 5'd0, 32'd50, 32'd8, 32'd42, 1'b0, 1'b0, 0, 0);
    chk32("bp.resume_cycles", cyc - c0, 32'd1);

    // Asynchronous reset in the middle of a mult
    idle(1);
    send("rst_mult", 2'b10, 6'b011000, 5'd0, 32'd5, 32'd6, 32'd30, 1'b0, 1'b0, 0, 0);
    idle(11);
    chk32("rst.hi_before", hi, model_hi);
    rst = 1'b1;
    #1;
    chk1 ("rst.out_valid", out_valid, 1'b0);
    chk32("rst.hi", hi, 32'd0);
    chk32("rst.lo", lo, 32'd0);
    chk32("rst.result", result, 32'd0);
    chk1 ("rst.in_ready", in_ready, 1'b1);
    sb.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    idle(2);
    rst = 1'b0;
    send("post_rst_add", 2'b00, 6'd0, 5'd0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 0, 0);
    chk1("post_rst.out_valid", out_valid, 1'b1);

    idle(3);
    chk32("sb.drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
